// File: rtl/box_ave_sched.sv
// Round-robin scheduler that time-shares one box_ave averager across NUM_CH raw-data channels.
// Optional WAIT watchdog is built when BOX_AVE_SCHED_TIMEOUT_EN is defined.
module box_ave_sched #(
    parameter int NUM_CH         = 4,
    parameter int ADC_WIDTH      = 8,
    parameter int LPF_DEPTH_BITS = 4,
    parameter int SAMPLE_DIV     = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_CH-1:0]             ch_mask,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   ch_data_in,
    output logic                          avg_rstn,
    output logic                          avg_sample,
    output logic [ADC_WIDTH-1:0]          avg_raw_data,
    input  logic [ADC_WIDTH-1:0]          avg_data_in,
    input  logic                          avg_valid,
    output logic [ADC_WIDTH-1:0]          result_data,
    output logic [$clog2(NUM_CH)-1:0]     result_ch,
    output logic                          result_valid,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int CHW   = $clog2(NUM_CH);
    localparam int DIVW  = $clog2(SAMPLE_DIV);
    localparam int PERW  = LPF_DEPTH_BITS + 1;
    localparam int NWIN  = 1 << LPF_DEPTH_BITS;

    if (NUM_CH < 2 || SAMPLE_DIV < 4 || (SAMPLE_DIV % 2) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("box_ave_sched: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SAMPLE, S_WAIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CHW-1:0]        ptr_q, ptr_d;
    logic [CHW-1:0]        cur_q, cur_d;
    logic [DIVW-1:0]       div_q, div_d;
    logic [PERW-1:0]       per_q, per_d;
    logic [1:0]            vcnt_q, vcnt_d;
    logic                  done_q, done_d;
    logic                  avg_rstn_q, avg_rstn_d;
    logic                  avg_sample_q, avg_sample_d;
    logic [ADC_WIDTH-1:0]  avg_raw_q, avg_raw_d;
    logic [ADC_WIDTH-1:0]  res_data_q, res_data_d;
    logic [CHW-1:0]        res_ch_q, res_ch_d;
    logic                  res_valid_q, res_valid_d;
    logic                  busy_q, busy_d;
`ifdef BOX_AVE_SCHED_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic                  tmo_q, tmo_d;
`endif

    logic [CHW-1:0]        rr_base, rr_sel, rr_idx;
    logic                  rr_hit, go, launch;

    // First set mask bit strictly after rr_base, wrapping; rr_base itself is checked last.
    always_comb begin
        rr_base = (state_q == S_IDLE) ? ptr_q : cur_q;
        rr_sel  = rr_base;
        rr_hit  = 1'b0;
        rr_idx  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            rr_idx = CHW'((int'(rr_base) + i) % NUM_CH);
            if (!rr_hit && ch_mask[rr_idx]) begin
                rr_hit = 1'b1;
                rr_sel = rr_idx;
            end
        end
        go = enable && rr_hit;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        div_d      = div_q;
        per_d      = per_q;
        vcnt_d     = vcnt_q;
        done_d     = done_q;
        avg_raw_d  = avg_raw_q;
        res_data_d = res_data_q;
        launch     = 1'b0;
`ifdef BOX_AVE_SCHED_TIMEOUT_EN
        wcnt_d     = wcnt_q;
        tmo_d      = 1'b0;
`endif

        // The first valid after a clear carries the zeroed accumulator; only the second is real.
        if ((state_q == S_SAMPLE || state_q == S_WAIT) && avg_valid) begin
            if (vcnt_q == 2'd1) begin
                res_data_d = avg_data_in;
                done_d     = 1'b1;
            end
            if (vcnt_q != 2'd3) vcnt_d = vcnt_q + 2'd1;
        end

        case (state_q)
            S_IDLE: launch = 1'b1;
            S_CLEAR: begin
                state_d = S_SAMPLE;
                div_d   = '0;
                per_d   = '0;
                vcnt_d  = '0;
                done_d  = 1'b0;
`ifdef BOX_AVE_SCHED_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            S_SAMPLE: begin
                if (div_q == DIVW'(SAMPLE_DIV - 1)) begin
                    div_d = '0;
                    if (per_q == PERW'(NWIN)) state_d = S_WAIT;
                    else                      per_d   = per_q + PERW'(1);
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            S_WAIT: begin
                if (done_q) begin
                    state_d = S_DONE;
`ifdef BOX_AVE_SCHED_TIMEOUT_EN
                end else if (int'(wcnt_q) == TIMEOUT_CYCLES - 1) begin
                    tmo_d  = 1'b1;
                    ptr_d  = cur_q;
                    launch = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
`endif
                end
            end
            S_DONE: begin
                ptr_d  = cur_q;
                launch = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            if (go) begin
                state_d   = S_CLEAR;
                cur_d     = rr_sel;
                avg_raw_d = ch_data_in[int'(rr_sel)*ADC_WIDTH +: ADC_WIDTH];
            end else begin
                state_d   = S_IDLE;
            end
        end

        // Outputs are registered, so they are decoded from the next state.
        avg_rstn_d   = (state_d != S_CLEAR);
        avg_sample_d = (state_d == S_SAMPLE) && (div_d < DIVW'(SAMPLE_DIV / 2));
        res_valid_d  = (state_d == S_DONE);
        res_ch_d     = (state_d == S_DONE) ? cur_q : res_ch_q;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= CHW'(NUM_CH - 1);
            cur_q        <= '0;
            div_q        <= '0;
            per_q        <= '0;
            vcnt_q       <= '0;
            done_q       <= 1'b0;
            avg_rstn_q   <= 1'b0;
            avg_sample_q <= 1'b0;
            avg_raw_q    <= '0;
            res_data_q   <= '0;
            res_ch_q     <= '0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef BOX_AVE_SCHED_TIMEOUT_EN
            wcnt_q       <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_q        <= cur_d;
            div_q        <= div_d;
            per_q        <= per_d;
            vcnt_q       <= vcnt_d;
            done_q       <= done_d;
            avg_rstn_q   <= avg_rstn_d;
            avg_sample_q <= avg_sample_d;
            avg_raw_q    <= avg_raw_d;
            res_data_q   <= res_data_d;
            res_ch_q     <= res_ch_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
`ifdef BOX_AVE_SCHED_TIMEOUT_EN
            wcnt_q       <= wcnt_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign avg_rstn     = avg_rstn_q;
    assign avg_sample   = avg_sample_q;
    assign avg_raw_data = avg_raw_q;
    assign result_data  = res_data_q;
    assign result_ch    = res_ch_q;
    assign result_valid = res_valid_q;
    assign busy         = busy_q;
`ifdef BOX_AVE_SCHED_TIMEOUT_EN
    assign timeout_err  = tmo_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule
